// File: rtl/uart_rx_status_irq.sv
// UART line status (LSR), interrupt identification (IIR) and interrupt request.
// Sticky error bits, THRE pending tracking and priority-encoded interrupt source.
module uart_rx_status_irq (
    input  logic       PCLK,
    input  logic       PRESET,
    input  logic       push_rx_fifo,
    input  logic       pop_rx_fifo,
    input  logic [4:0] rx_fifo_count,
    input  logic       rx_fifo_empty,
    input  logic       rx_overrun,
    input  logic       parity_error,
    input  logic       framing_error,
    input  logic       break_error,
    input  logic       time_out,
    input  logic       tx_fifo_empty,
    input  logic       tx_idle,
    input  logic       tx_push,
    input  logic       lsr_rd,
    input  logic       iir_rd,
    input  logic [3:0] IER,
    input  logic [1:0] FCR_trig,
    output logic [7:0] LSR,
    output logic [3:0] IIR,
    output logic       irq
);

    logic       dr_q, thre_q, temt_q;
    logic       oe_q, pe_q, fe_q, bi_q, err_q;
    logic       oe_d, pe_d, fe_d, bi_d, err_d;
    logic       brk_prev_q, txe_prev_q, ier1_prev_q;
    logic       thre_pend_q, thre_pend_d;
    logic [3:0] iir_q, iir_d;
    logic       irq_q;
    logic [4:0] level;
    logic       rda_cond, thre_set, thre_clr;
    logic       set_oe, set_pe, set_fe, set_bi;

    // Pop only moves occupancy, which arrives through rx_fifo_count; IER[3] is reserved.
    logic unused_ok;
    assign unused_ok = &{1'b0, pop_rx_fifo, IER[3]};

    always_comb begin
        set_oe = push_rx_fifo & rx_overrun;
        set_pe = push_rx_fifo & parity_error;
        set_fe = push_rx_fifo & framing_error;
        set_bi = break_error & ~brk_prev_q;

        // A set in the same cycle as the LSR read wins over the clear.
        oe_d  = set_oe | (oe_q & ~lsr_rd);
        pe_d  = set_pe | (pe_q & ~lsr_rd);
        fe_d  = set_fe | (fe_q & ~lsr_rd);
        bi_d  = set_bi | (bi_q & ~lsr_rd);
        err_d = (set_oe | set_pe | set_fe | set_bi) | (err_q & ~lsr_rd);

        level = 5'd1;
        case (FCR_trig)
            2'b00: level = 5'd1;
            2'b01: level = 5'd4;
            2'b10: level = 5'd8;
            2'b11: level = 5'd14;
            default: level = 5'd1;
        endcase
        rda_cond = (rx_fifo_count >= level);

        thre_set = (tx_fifo_empty & ~txe_prev_q) | (tx_fifo_empty & IER[1] & ~ier1_prev_q);
        thre_clr = tx_push | (iir_rd & (iir_q == 4'b0010));
        thre_pend_d = thre_set | (thre_pend_q & ~thre_clr);

        iir_d = 4'b0001;
        if (IER[2] & (oe_d | pe_d | fe_d | bi_d))
            iir_d = 4'b0110;
        else if (IER[0] & rda_cond)
            iir_d = 4'b0100;
        else if (IER[0] & time_out & ~rx_fifo_empty)
            iir_d = 4'b1100;
        else if (IER[1] & thre_pend_d)
            iir_d = 4'b0010;
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            dr_q        <= 1'b0;
            thre_q      <= 1'b1;
            temt_q      <= 1'b1;
            oe_q        <= 1'b0;
            pe_q        <= 1'b0;
            fe_q        <= 1'b0;
            bi_q        <= 1'b0;
            err_q       <= 1'b0;
            brk_prev_q  <= 1'b0;
            txe_prev_q  <= 1'b0;
            ier1_prev_q <= 1'b0;
            thre_pend_q <= 1'b0;
            iir_q       <= 4'b0001;
            irq_q       <= 1'b0;
        end else begin
            dr_q        <= ~rx_fifo_empty;
            thre_q      <= tx_fifo_empty;
            temt_q      <= tx_fifo_empty & tx_idle;
            oe_q        <= oe_d;
            pe_q        <= pe_d;
            fe_q        <= fe_d;
            bi_q        <= bi_d;
            err_q       <= err_d;
            brk_prev_q  <= break_error;
            txe_prev_q  <= tx_fifo_empty;
            ier1_prev_q <= IER[1];
            thre_pend_q <= thre_pend_d;
            iir_q       <= iir_d;
            irq_q       <= ~iir_d[0];
        end
    end

    assign LSR = {err_q, temt_q, thre_q, bi_q, fe_q, pe_q, oe_q, dr_q};
    assign IIR = iir_q;
    assign irq = irq_q;

endmodule

// File: tb/tb_uart_rx_status_irq.sv
// Self-checking bench for uart_rx_status_irq: directed scenarios plus a randomized
// run compared against a cycle-level reference model of the status/interrupt rules.
module tb_uart_rx_status_irq;

    logic       PCLK = 1'b0;
    logic       PRESET, push_rx_fifo, pop_rx_fifo, rx_fifo_empty;
    logic [4:0] rx_fifo_count;
    logic       rx_overrun, parity_error, framing_error, break_error, time_out;
    logic       tx_fifo_empty, tx_idle, tx_push, lsr_rd, iir_rd;
    logic [3:0] IER;
    logic [1:0] FCR_trig;
    logic [7:0] LSR;
    logic [3:0] IIR;
    logic       irq;

    int n_tests = 0;
    int n_fail  = 0;

    uart_rx_status_irq dut (
        .PCLK(PCLK), .PRESET(PRESET), .push_rx_fifo(push_rx_fifo), .pop_rx_fifo(pop_rx_fifo),
        .rx_fifo_count(rx_fifo_count), .rx_fifo_empty(rx_fifo_empty), .rx_overrun(rx_overrun),
        .parity_error(parity_error), .framing_error(framing_error), .break_error(break_error),
        .time_out(time_out), .tx_fifo_empty(tx_fifo_empty), .tx_idle(tx_idle), .tx_push(tx_push),
        .lsr_rd(lsr_rd), .iir_rd(iir_rd), .IER(IER), .FCR_trig(FCR_trig),
        .LSR(LSR), .IIR(IIR), .irq(irq)
    );

    always #5 PCLK = ~PCLK;

    // Reference model state: LSR image, edge history, THRE pending, IIR/irq.
    logic [7:0] m_lsr;
    logic [3:0] m_iir;
    logic       m_irq, m_brk_prev, m_txe_prev, m_ier1_prev, m_thre;
    int         trig_lvl [4] = '{1, 4, 8, 14};

    task automatic check_eq(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_update();
        logic [3:0] errs;
        logic [3:0] sticky;
        logic       new_err;
        if (PRESET) begin
            m_lsr = 8'h60; m_iir = 4'b0001; m_irq = 1'b0;
            m_brk_prev = 1'b0; m_txe_prev = 1'b0; m_ier1_prev = 1'b0; m_thre = 1'b0;
            return;
        end
        // errs ordered as LSR[4:1]: BI, FE, PE, OE
        errs = {break_error & ~m_brk_prev, push_rx_fifo & framing_error,
                push_rx_fifo & parity_error, push_rx_fifo & rx_overrun};
        new_err = |errs;
        sticky  = errs | (lsr_rd ? 4'b0000 : m_lsr[4:1]);
        if ((tx_fifo_empty && !m_txe_prev) || (tx_fifo_empty && IER[1] && !m_ier1_prev))
            m_thre = 1'b1;
        else if (tx_push || (iir_rd && m_iir == 4'b0010))
            m_thre = 1'b0;
        m_lsr[7]   = new_err || (m_lsr[7] && !lsr_rd);
        m_lsr[6]   = tx_fifo_empty & tx_idle;
        m_lsr[5]   = tx_fifo_empty;
        m_lsr[4:1] = sticky;
        m_lsr[0]   = ~rx_fifo_empty;
        if (IER[2] && sticky != 0)                                 m_iir = 4'b0110;
        else if (IER[0] && int'(rx_fifo_count) >= trig_lvl[FCR_trig]) m_iir = 4'b0100;
        else if (IER[0] && time_out && !rx_fifo_empty)             m_iir = 4'b1100;
        else if (IER[1] && m_thre)                                 m_iir = 4'b0010;
        else                                                       m_iir = 4'b0001;
        m_irq = (m_iir != 4'b0001);
        m_brk_prev = break_error; m_txe_prev = tx_fifo_empty; m_ier1_prev = IER[1];
    endtask

    task automatic step();
        @(posedge PCLK);
        model_update();
        #1;
        check_eq("model_lsr", LSR, m_lsr);
        check_eq("model_iir", {4'h0, IIR}, {4'h0, m_iir});
        check_eq("model_irq", {7'h0, irq}, {7'h0, m_irq});
    endtask

    task automatic clear_strobes();
        push_rx_fifo = 0; pop_rx_fifo = 0; rx_overrun = 0; parity_error = 0;
        framing_error = 0; tx_push = 0; lsr_rd = 0; iir_rd = 0;
    endtask

    initial begin
        PRESET = 1; clear_strobes();
        rx_fifo_count = 0; rx_fifo_empty = 1; break_error = 0; time_out = 0;
        tx_fifo_empty = 1; tx_idle = 1; IER = 4'b0000; FCR_trig = 2'b00;
        step();
        check_eq("reset_lsr", LSR, 8'h60);
        check_eq("reset_iir", {4'h0, IIR}, 8'h01);
        check_eq("reset_irq", {7'h0, irq}, 8'h00);
        PRESET = 0;
        step();

        // RDA threshold crossing at trigger level 4
        IER = 4'b0001; FCR_trig = 2'b01; rx_fifo_count = 3; rx_fifo_empty = 0;
        step();
        rx_fifo_count = 4; step();
        check_eq("rda_set_iir", {4'h0, IIR}, 8'h04);
        check_eq("rda_set_irq", {7'h0, irq}, 8'h01);
        rx_fifo_count = 3; step();
        check_eq("rda_clr_iir", {4'h0, IIR}, 8'h01);
        check_eq("rda_clr_irq", {7'h0, irq}, 8'h00);

        // Parity error sticky, line status interrupt, cleared by LSR read
        IER = 4'b0100; push_rx_fifo = 1; parity_error = 1; step();
        clear_strobes();
        check_eq("pe_set", {7'h0, LSR[2]}, 8'h01);
        check_eq("err_sum_set", {7'h0, LSR[7]}, 8'h01);
        check_eq("ls_iir", {4'h0, IIR}, 8'h06);
        lsr_rd = 1; step(); clear_strobes();
        check_eq("pe_clr", {7'h0, LSR[2]}, 8'h00);
        check_eq("ls_clr_iir", {4'h0, IIR}, 8'h01);

        // Set coincident with read wins
        push_rx_fifo = 1; framing_error = 1; step();
        lsr_rd = 1; step(); clear_strobes();
        check_eq("fe_set_wins", {7'h0, LSR[3]}, 8'h01);
        lsr_rd = 1; step(); clear_strobes();

        // Priority walk-down: line status > RDA > THRE > none
        IER = 4'b0111; rx_fifo_count = 4; push_rx_fifo = 1; parity_error = 1; step();
        clear_strobes();
        check_eq("prio_ls", {4'h0, IIR}, 8'h06);
        lsr_rd = 1; step(); clear_strobes();
        check_eq("prio_rda", {4'h0, IIR}, 8'h04);
        rx_fifo_count = 0; rx_fifo_empty = 1; step();
        check_eq("prio_thre", {4'h0, IIR}, 8'h02);
        iir_rd = 1; step(); clear_strobes();
        check_eq("thre_iir_rd", {4'h0, IIR}, 8'h01);

        // Character timeout below trigger level
        IER = 4'b0001; FCR_trig = 2'b10; rx_fifo_count = 2; rx_fifo_empty = 0; time_out = 1;
        step();
        check_eq("timeout_iir", {4'h0, IIR}, 8'h0c);
        rx_fifo_count = 0; rx_fifo_empty = 1; step();
        check_eq("timeout_clr_iir", {4'h0, IIR}, 8'h01);
        check_eq("timeout_clr_irq", {7'h0, irq}, 8'h00);
        time_out = 0;

        // Full FIFO meets the highest level; empty meets none
        FCR_trig = 2'b11; rx_fifo_count = 16; rx_fifo_empty = 0; step();
        check_eq("full_lvl14", {4'h0, IIR}, 8'h04);
        FCR_trig = 2'b00; rx_fifo_count = 0; rx_fifo_empty = 1; step();
        check_eq("empty_lvl1", {4'h0, IIR}, 8'h01);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            PRESET        = ($urandom_range(0, 99) == 0);
            push_rx_fifo  = ($urandom_range(0, 3) == 0);
            pop_rx_fifo   = ($urandom_range(0, 3) == 0);
            rx_overrun    = ($urandom_range(0, 7) == 0);
            parity_error  = ($urandom_range(0, 7) == 0);
            framing_error = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 9) == 0) break_error = ~break_error;
            time_out      = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 7) == 0) tx_fifo_empty = ~tx_fifo_empty;
            tx_idle       = $urandom_range(0, 1);
            tx_push       = ($urandom_range(0, 15) == 0);
            lsr_rd        = ($urandom_range(0, 9) == 0);
            iir_rd        = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 19) == 0) IER = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 29) == 0) FCR_trig = 2'($urandom_range(0, 3));
            rx_fifo_count = 5'($urandom_range(0, 16));
            rx_fifo_empty = (rx_fifo_count == 0);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx_status_irq.md
UART_RX_STATUS_IRQ -- requirements
Module: uart_rx_status_irq

Interface
REQ-001 SHALL have port PCLK, input, 1, sole clock; all state updates on its rising edge.
REQ-002 SHALL have port PRESET, input, 1, reset; synchronous, active-high.
REQ-003 SHALL have ports push_rx_fifo, pop_rx_fifo, input, 1 each, RX FIFO write/read strobes from receiver/APB.
REQ-004 SHALL have ports rx_fifo_count, input, 5, RX FIFO occupancy 0..16; rx_fifo_empty, input, 1.
REQ-005 SHALL have ports rx_overrun, parity_error, framing_error, break_error, time_out, input, 1 each, receiver status.
REQ-006 SHALL have ports tx_fifo_empty, tx_idle, tx_push, input, 1 each, transmitter status/THR write strobe.
REQ-007 SHALL have ports lsr_rd, iir_rd, input, 1 each, single-cycle APB read strobes of LSR/IIR.
REQ-008 SHALL have ports IER, input, 4, interrupt enables (bit0 RDA/timeout, bit1 THRE, bit2 line status, bit3 unused); FCR_trig, input, 2, RX trigger level select.
REQ-009 SHALL have ports LSR, output, 8, line status register; IIR, output, 4, interrupt identification; irq, output, 1, interrupt request.

Function
REQ-010 LSR bits SHALL be: [0] DR, [1] OE, [2] PE, [3] FE, [4] BI, [5] THRE, [6] TEMT, [7] RX error summary.
REQ-011 LSR[0] SHALL be registered ~rx_fifo_empty; LSR[5] registered tx_fifo_empty; LSR[6] registered tx_fifo_empty & tx_idle; 1-cycle latency.
REQ-012 OE/PE/FE SHALL set sticky in the cycle after push_rx_fifo=1 with rx_overrun/parity_error/framing_error=1 respectively.
REQ-013 BI SHALL set sticky in the cycle after a 0->1 transition of break_error (edge detect register).
REQ-014 LSR[7] SHALL set sticky when any of OE/PE/FE/BI sets; cleared with them.
REQ-015 Sticky bits LSR[4:1] and LSR[7] SHALL clear in the cycle after lsr_rd=1; a set condition in the same cycle as lsr_rd SHALL win (bit remains 1).
REQ-016 Trigger level SHALL map FCR_trig 00->1, 01->4, 10->8, 11->14; rda_cond = rx_fifo_count >= level (5-bit unsigned compare).
REQ-017 thre_pend SHALL set on a 0->1 edge of tx_fifo_empty or 0->1 edge of IER[1] while tx_fifo_empty=1; clear on tx_push, or on iir_rd while IIR=4'b0010; set wins over clear in same cycle.
REQ-018 IIR SHALL be registered, priority highest first: IER[2] & |LSR[4:1] -> 0110; IER[0] & rda_cond -> 0100; IER[0] & time_out & ~rx_fifo_empty -> 1100; IER[1] & thre_pend -> 0010; else 0001.
REQ-019 irq SHALL be registered and equal ~IIR[0] of the same cycle (computed from the same next-state).
REQ-020 Disabling an IER bit SHALL remove its source from IIR/irq in the next cycle without clearing LSR sticky bits or thre_pend (except thre_pend edge rule above).
REQ-021 Line-status interrupt SHALL clear only via lsr_rd; RDA via count dropping below level; timeout via time_out=0 or FIFO empty.
REQ-022 Simultaneous push_rx_fifo and pop_rx_fifo SHALL have no effect on status beyond REQ-012; DR follows rx_fifo_empty only.
REQ-023 rx_fifo_count=16 (full) SHALL satisfy all trigger levels; count 0 SHALL satisfy none.

Reset
REQ-024 With PRESET=1 at a PCLK edge: LSR=8'h60, IIR=4'b0001, irq=0, thre_pend=0, break edge register=0.
REQ-025 PRESET asserted mid-operation SHALL abandon pending interrupts and sticky bits; no status survives reset.

Verification
REQ-026 Reset, tx_fifo_empty=1, tx_idle=1 -> LSR=8'h60, IIR=0001, irq=0.
REQ-027 IER=0001, FCR_trig=01, raise count 3->4 -> next cycle IIR=0100, irq=1; count 4->3 -> IIR=0001, irq=0.
REQ-028 IER=0100, push_rx_fifo with parity_error=1 -> LSR[2]=1, LSR[7]=1, IIR=0110; lsr_rd -> LSR[2]=0, IIR=0001.
REQ-029 lsr_rd coincident with push_rx_fifo+framing_error -> LSR[3] stays 1 after the read.
REQ-030 IER=0111, PE sticky and count>=trigger and thre_pend -> IIR=0110; after lsr_rd IIR=0100; drain FIFO -> IIR=0010; iir_rd -> IIR=0001.
REQ-031 IER=0001, count=2, FCR_trig=10, time_out=1 -> IIR=1100; pop to empty -> IIR=0001, irq=0.
